// File: rtl/sram_2rw_param.sv
// Two-port read/write SRAM behavioural model with per-lane write masks,
// 1- or 2-cycle read latency, read-valid strobes and a same-address collision flag.
module sram_2rw_param #(
  parameter int WORDS    = 32,
  parameter int BITS     = 4,
  parameter int ADDR_W   = $clog2(WORDS),
  parameter int GRAN     = BITS,
  parameter int READ_LAT = 1,
  localparam int MW      = BITS / GRAN
) (
  input  logic              CE,
  input  logic              RSTB,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic              CSB1,
  input  logic              CSB2,
  input  logic              WEB1,
  input  logic              WEB2,
  input  logic              OEB1,
  input  logic              OEB2,
  input  logic [MW-1:0]     BMB1,
  input  logic [MW-1:0]     BMB2,
  input  logic [BITS-1:0]   I1,
  input  logic [BITS-1:0]   I2,
  output logic [BITS-1:0]   O1,
  output logic [BITS-1:0]   O2,
  output logic              OV1,
  output logic              OV2,
  output logic              COLL
);

  localparam logic [ADDR_W:0] WORDS_W = (ADDR_W + 1)'(WORDS);

  // Index 0 is port 1, index 1 is port 2.
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][MW-1:0]     bmb;
  logic [1:0][BITS-1:0]   wdata;
  logic [1:0]             csb, web, oeb;
  logic [1:0]             re, we, in_rng;
  logic [1:0][BITS-1:0]   rdata;

  logic [BITS-1:0] mem_q [WORDS];
  logic [BITS-1:0] mem_d [WORDS];

  logic [1:0][BITS-1:0] s1_q, s1_d;
  logic [1:0]           s1v_q, s1v_d;
  logic [1:0][BITS-1:0] o_q, o_d;
  logic [1:0]           ov_q, ov_d;
  logic                 coll_q, coll_d;

  assign addr  = {A2, A1};
  assign bmb   = {BMB2, BMB1};
  assign wdata = {I2, I1};
  assign csb   = {CSB2, CSB1};
  assign web   = {WEB2, WEB1};
  assign oeb   = {OEB2, OEB1};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      re[p]     = !csb[p] && !oeb[p];
      we[p]     = !csb[p] && !web[p];
      in_rng[p] = ({1'b0, addr[p]} < WORDS_W);
      rdata[p]  = in_rng[p] ? mem_q[addr[p]] : '0;
    end
  end

  // NOTE: combinational blocks use blocking '=' so later statements see earlier
  // results; here port 1 is applied last so it overrides port 2 lane by lane.
  always_comb begin
    mem_d = mem_q;
    for (int p = 1; p >= 0; p--) begin
      if (we[p] && in_rng[p]) begin
        for (int k = 0; k < MW; k++) begin
          if (!bmb[p][k]) mem_d[addr[p]][k*GRAN +: GRAN] = wdata[p][k*GRAN +: GRAN];
        end
      end
    end
  end

  // NOTE: the storage array has no reset; contents must survive RSTB, and a
  // reset on a large array would turn it into a flop bank.
  always_ff @(posedge CE) begin
    mem_q <= mem_d;
  end

  // Reads sample mem_q, so a read always sees the pre-write word.
  always_comb begin
    coll_d = in_rng[0] && in_rng[1] && (addr[0] == addr[1]) &&
             ((we[0] && we[1]) || (we[0] && re[1]) || (we[1] && re[0]));
  end

  always_comb begin
    s1_d  = s1_q;
    s1v_d = '0;
    o_d   = o_q;
    ov_d  = '0;
    for (int p = 0; p < 2; p++) begin
      if (READ_LAT == 2) begin
        if (re[p])    s1_d[p] = rdata[p];
        s1v_d[p] = re[p];
        if (s1v_q[p]) o_d[p]  = s1_q[p];
        ov_d[p]  = s1v_q[p];
      end else begin
        if (re[p]) o_d[p] = rdata[p];
        ov_d[p] = re[p];
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      s1_q   <= '0;
      s1v_q  <= '0;
      o_q    <= '0;
      ov_q   <= '0;
      coll_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s1v_q  <= s1v_d;
      o_q    <= o_d;
      ov_q   <= ov_d;
      coll_q <= coll_d;
    end
  end

  assign O1   = o_q[0];
  assign O2   = o_q[1];
  assign OV1  = ov_q[0];
  assign OV2  = ov_q[1];
  assign COLL = coll_q;

endmodule
